// File: rtl/i2c_target_regfile.sv
// I2C target on an oversampled SCL/SDA pair, fronting a 2^REG_AW x 8 register
// file with pointer auto-increment, a core-side read port and a write strobe.
module i2c_target_regfile #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              CLK_IN,
   input  logic              RESET_N_IN,
   input  logic              SCL_IN,
   input  logic              SDA_IN,
   output logic              SDA_OE_OUT,
   input  logic [REG_AW-1:0] CORE_RADDR_IN,
   output logic [7:0]        CORE_RDATA_OUT,
   output logic              WR_PULSE_OUT,
   output logic [REG_AW-1:0] WR_ADDR_OUT,
   output logic [7:0]        WR_DATA_OUT,
   output logic              BUSY_OUT
);

   localparam int unsigned       DEPTH   = 1 << REG_AW;
   localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_WAIT_STOP
   } state_t;

   // Reset asserts asynchronously everywhere but leaves reset on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   // NOTE: sequential state is only ever assigned with <= so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) rst_sync <= '0;
      else             rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;
   logic                   scl_s, sda_s;

   // Bus idles high, so the synchronisers reset to 1 to avoid a false START.
   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_IN};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_IN};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

   state_t            state, state_n;
   logic [2:0]        bit_cnt, bit_cnt_n;
   logic [7:0]        shift, shift_n;
   logic [REG_AW-1:0] ptr, ptr_n;
   logic              sda_oe, sda_oe_n;
   logic              ack_phase, ack_phase_n;
   logic              busy, busy_n;
   logic              rw, rw_n;
   logic              wr_pulse, wr_pulse_n;
   logic [REG_AW-1:0] wr_addr, wr_addr_n;
   logic [7:0]        wr_data, wr_data_n;
   logic              reg_we;

   logic [7:0] regs [DEPTH];
   logic [7:0] shifted;
   logic [7:0] rd_byte;

   assign shifted        = {shift[6:0], sda_s};
   assign rd_byte        = regs[ptr];
   assign CORE_RDATA_OUT = regs[CORE_RADDR_IN];

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      ptr_n       = ptr;
      sda_oe_n    = sda_oe;
      ack_phase_n = ack_phase;
      busy_n      = busy;
      rw_n        = rw;
      wr_pulse_n  = 1'b0;
      wr_addr_n   = wr_addr;
      wr_data_n   = wr_data;
      reg_we      = 1'b0;

      if (stop_det) begin
         state_n     = ST_IDLE;
         sda_oe_n    = 1'b0;
         busy_n      = 1'b0;
         bit_cnt_n   = '0;
         ack_phase_n = 1'b0;
      end else if (start_det) begin
         state_n     = ST_ADDR;
         sda_oe_n    = 1'b0;
         bit_cnt_n   = '0;
         ack_phase_n = 1'b0;
      end else begin
         unique case (state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_n   = shifted;
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_phase_n = 1'b0;
                     if (state == ST_ADDR) begin
                        if (shifted[7:1] == SLAVE_ADDR) begin
                           busy_n  = 1'b1;
                           rw_n    = shifted[0];
                           state_n = ST_ADDR_ACK;
                        end else begin
                           busy_n  = 1'b0;
                           state_n = ST_WAIT_STOP;
                        end
                     end else if (state == ST_PTR) begin
                        ptr_n   = shifted[REG_AW-1:0];
                        state_n = ST_PTR_ACK;
                     end else begin
                        reg_we     = 1'b1;
                        wr_pulse_n = 1'b1;
                        wr_addr_n  = ptr;
                        wr_data_n  = shifted;
                        state_n    = ST_WDATA_ACK;
                     end
                  end
               end
            end

            // First fall pulls SDA for the ACK, second fall ends the ACK pulse.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe_n    = 1'b1;
                     ack_phase_n = 1'b1;
                  end else begin
                     ack_phase_n = 1'b0;
                     sda_oe_n    = 1'b0;
                     bit_cnt_n   = '0;
                     if (state == ST_ADDR_ACK && rw) begin
                        state_n  = ST_RDATA;
                        sda_oe_n = ~rd_byte[7];
                        shift_n  = {rd_byte[6:0], 1'b0};
                     end else if (state == ST_WDATA_ACK) begin
                        ptr_n   = ptr + PTR_ONE;
                        state_n = ST_WDATA;
                     end else if (state == ST_PTR_ACK) begin
                        state_n = ST_WDATA;
                     end else begin
                        state_n = ST_PTR;
                     end
                  end
               end
            end

            // Bit 7 was driven on entry; each later fall drives the next bit.
            ST_RDATA: begin
               if (scl_fall) begin
                  sda_oe_n = ~shift[7];
                  shift_n  = {shift[6:0], 1'b0};
               end
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state_n     = ST_RDATA_ACK;
                     ack_phase_n = 1'b0;
                  end
               end
            end

            ST_RDATA_ACK: begin
               if (scl_fall && !ack_phase) begin
                  sda_oe_n    = 1'b0;
                  ack_phase_n = 1'b1;
               end else if (scl_rise && ack_phase) begin
                  if (sda_s) begin
                     state_n     = ST_WAIT_STOP;
                     ack_phase_n = 1'b0;
                  end else begin
                     ptr_n = ptr + PTR_ONE;
                  end
               end else if (scl_fall && ack_phase) begin
                  ack_phase_n = 1'b0;
                  bit_cnt_n   = '0;
                  state_n     = ST_RDATA;
                  sda_oe_n    = ~rd_byte[7];
                  shift_n     = {rd_byte[6:0], 1'b0};
               end
            end

            ST_IDLE, ST_WAIT_STOP: ;

            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         ack_phase <= 1'b0;
         busy      <= 1'b0;
         rw        <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         ptr       <= ptr_n;
         sda_oe    <= sda_oe_n;
         ack_phase <= ack_phase_n;
         busy      <= busy_n;
         rw        <= rw_n;
         wr_pulse  <= wr_pulse_n;
         wr_addr   <= wr_addr_n;
         wr_data   <= wr_data_n;
      end
   end

   // NOTE: the register file is reset because its post-reset contents are
   // architecturally visible; this commits it to flops rather than a RAM macro.
   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[ptr] <= shifted;
      end
   end

   assign SDA_OE_OUT   = sda_oe;
   assign BUSY_OUT     = busy;
   assign WR_PULSE_OUT = wr_pulse;
   assign WR_ADDR_OUT  = wr_addr;
   assign WR_DATA_OUT  = wr_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master on a wired-AND
// SDA line, with hand-computed expectations for every comparison.
module tb_i2c_target_regfile;

   localparam int REG_AW = 4;
   localparam int Q      = 100;  // quarter SCL period, 10 system clocks

   logic              clk = 1'b0;
   logic              rst_n;
   logic              scl;
   logic              sda_drv;
   logic              sda_line;
   logic              sda_oe;
   logic [REG_AW-1:0] raddr;
   logic [7:0]        rdata;
   logic              wr_pulse;
   logic [REG_AW-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;

   always #5 clk = ~clk;

   assign sda_line = sda_drv & ~sda_oe;

   i2c_target_regfile #(
      .SLAVE_ADDR  (7'h50),
      .REG_AW      (REG_AW),
      .SYNC_STAGES (2)
   ) dut (
      .CLK_IN         (clk),
      .RESET_N_IN     (rst_n),
      .SCL_IN         (scl),
      .SDA_IN         (sda_line),
      .SDA_OE_OUT     (sda_oe),
      .CORE_RADDR_IN  (raddr),
      .CORE_RDATA_OUT (rdata),
      .WR_PULSE_OUT   (wr_pulse),
      .WR_ADDR_OUT    (wr_addr),
      .WR_DATA_OUT    (wr_data),
      .BUSY_OUT       (busy)
   );

   int                tests_run    = 0;
   int                tests_failed = 0;
   int                pulse_cnt    = 0;
   int                oe_high_cnt  = 0;
   int                busy_high_cnt = 0;
   logic [REG_AW-1:0] pulse_addr [8];
   logic [7:0]        pulse_data [8];

   always @(negedge clk) begin
      if (wr_pulse) begin
         if (pulse_cnt < 8) begin
            pulse_addr[pulse_cnt] <= wr_addr;
            pulse_data[pulse_cnt] <= wr_data;
         end
         pulse_cnt <= pulse_cnt + 1;
      end
      if (sda_oe) oe_high_cnt <= oe_high_cnt + 1;
      if (busy) busy_high_cnt <= busy_high_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; #Q;
      scl     = 1'b1; #Q;
      sda_drv = 1'b0; #Q;
      scl     = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; #Q;
      scl     = 1'b1; #Q;
      sda_drv = 1'b1; #Q;
      repeat (10) @(negedge clk);
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b; #Q;
      scl     = 1'b1; #(2*Q);
      scl     = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic b);
      sda_drv = 1'b1; #Q;
      scl     = 1'b1; #Q;
      b       = sda_line; #Q;
      scl     = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(a);
      acked = ~a;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~master_ack);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic              ack;
      logic [7:0]        d;
      int                p0, oe0, b0;
      logic [REG_AW-1:0] exp_a [3];
      logic [7:0]        exp_d [3];

      exp_a = '{4'd14, 4'd15, 4'd0};
      exp_d = '{8'h11, 8'h22, 8'h33};

      rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b1; raddr = '0;
      repeat (4) @(negedge clk);
      check("reset sda_oe",   32'(sda_oe),   32'd0);
      check("reset wr_pulse", 32'(wr_pulse), 32'd0);
      check("reset wr_addr",  32'(wr_addr),  32'd0);
      check("reset wr_data",  32'(wr_data),  32'd0);
      check("reset busy",     32'(busy),     32'd0);
      check("reset reg0",     32'(rdata),    32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write burst starting at 14, wrapping to 0.
      i2c_start();
      write_byte(8'hA0, ack); check("burst addr ack", 32'(ack), 32'd1);
      check("burst busy set", 32'(busy), 32'd1);
      write_byte(8'h0E, ack); check("burst ptr ack", 32'(ack), 32'd1);
      for (int i = 0; i < 3; i++) begin
         write_byte(exp_d[i], ack);
         check($sformatf("burst data%0d ack", i), 32'(ack), 32'd1);
      end
      i2c_stop();
      check("burst busy clear", 32'(busy), 32'd0);
      check("burst pulse count", 32'(pulse_cnt), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("burst wr_addr%0d", i), 32'(pulse_addr[i]), 32'(exp_a[i]));
         check($sformatf("burst wr_data%0d", i), 32'(pulse_data[i]), 32'(exp_d[i]));
      end

      raddr = 4'd15; #1; check("core rd 15", 32'(rdata), 32'h22);
      raddr = 4'd14; #1; check("core rd 14", 32'(rdata), 32'h11);
      raddr = 4'd0;  #1; check("core rd 0",  32'(rdata), 32'h33);

      // Pointer write, repeated START, 3-byte read.
      i2c_start();
      write_byte(8'hA0, ack); check("rd waddr ack", 32'(ack), 32'd1);
      write_byte(8'h0E, ack); check("rd ptr ack",   32'(ack), 32'd1);
      i2c_start();
      write_byte(8'hA1, ack); check("rd raddr ack", 32'(ack), 32'd1);
      read_byte(1'b1, d); check("rd byte0", 32'(d), 32'h11);
      read_byte(1'b1, d); check("rd byte1", 32'(d), 32'h22);
      read_byte(1'b0, d); check("rd byte2", 32'(d), 32'h33);
      check("rd oe after nack", 32'(sda_oe), 32'd0);
      i2c_stop();
      check("rd no write pulses", 32'(pulse_cnt), 32'd3);

      // Address mismatch: no ACK, no drive, no busy, no write.
      p0 = pulse_cnt; oe0 = oe_high_cnt; b0 = busy_high_cnt;
      i2c_start();
      write_byte(8'hA2, ack); check("mismatch addr nack", 32'(ack), 32'd0);
      write_byte(8'h55, ack); check("mismatch data nack", 32'(ack), 32'd0);
      i2c_stop();
      check("mismatch oe cycles",   32'(oe_high_cnt - oe0),   32'd0);
      check("mismatch busy cycles", 32'(busy_high_cnt - b0),  32'd0);
      check("mismatch pulses",      32'(pulse_cnt - p0),      32'd0);
      raddr = 4'd5; #1; check("mismatch reg5", 32'(rdata), 32'h00);

      // STOP after 5 data bits discards the partial byte.
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("partial addr ack", 32'(ack), 32'd1);
      write_byte(8'h03, ack); check("partial ptr ack",  32'(ack), 32'd1);
      repeat (5) write_bit(1'b1);
      i2c_stop();
      check("partial pulses", 32'(pulse_cnt - p0), 32'd0);
      check("partial busy",   32'(busy),           32'd0);
      check("partial oe",     32'(sda_oe),         32'd0);
      raddr = 4'd3; #1; check("partial reg3", 32'(rdata), 32'h00);

      // Reset while the target drives the first read bit (0x11 -> MSB 0).
      i2c_start();
      write_byte(8'hA0, ack); check("rst waddr ack", 32'(ack), 32'd1);
      write_byte(8'h0E, ack); check("rst ptr ack",   32'(ack), 32'd1);
      i2c_start();
      write_byte(8'hA1, ack); check("rst raddr ack", 32'(ack), 32'd1);
      check("rst oe driving", 32'(sda_oe), 32'd1);
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      check("rst oe async", 32'(sda_oe), 32'd0);
      check("rst busy async", 32'(busy), 32'd0);
      scl = 1'b1; sda_drv = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < (1 << REG_AW); i++) begin
         raddr = REG_AW'(i); #1;
         check($sformatf("rst clear reg%0d", i), 32'(rdata), 32'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
